// File: rtl/fir_serial_mac_if.sv
// Bus bundle for fir_serial_mac: sample in, coefficient ROM port, filtered sample out.
// No latency of its own; it only groups wires.
// The DUT side takes the slave modport. The sample source and ROM side take the master modport.
interface fir_serial_mac_if #(
  parameter int AW = 5,
  parameter int DW = 16
);
  logic signed [DW-1:0] din;
  logic                 din_valid;
  logic                 mode_in;
  logic [AW-1:0]        coef_addr;
  logic                 coef_mode;
  logic signed [DW-1:0] coef_in;
  logic signed [DW-1:0] dout;
  logic                 dout_valid;
  logic                 busy;
  logic                 drop_err;

  modport slave (
    input  din, din_valid, mode_in, coef_in,
    output coef_addr, coef_mode, dout, dout_valid, busy, drop_err
  );

  modport master (
    output din, din_valid, mode_in, coef_in,
    input  coef_addr, coef_mode, dout, dout_valid, busy, drop_err
  );
endinterface

// File: rtl/fir_serial_mac.sv
// Time-multiplexed 32-tap FIR: one multiply-accumulate per cycle, then a rounded and saturated Q1.15 output.
// Latency: din_valid in cycle 0 gives dout_valid in cycle 35. At most one sample is taken every 36 cycles.
// Backpressure: none. busy marks the window in which strobes are dropped; a dropped strobe sets the sticky drop_err.
module fir_serial_mac #(
  parameter int NTAPS = 32,
  parameter int AW    = 5,
  parameter int DW    = 16,
  parameter int ACCW  = 38
) (
  input logic            clk,
  input logic            rst,
  fir_serial_mac_if.slave io
);
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_FLUSH, S_DONE} state_t;

  localparam logic [AW-1:0]          LAST_TAP = AW'(NTAPS - 1);
  localparam logic signed [ACCW-1:0] RND      = ACCW'(2 ** (DW - 2));
  localparam logic signed [ACCW-1:0] SAT_MAX  = ACCW'(2 ** (DW - 1) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN  = ~SAT_MAX;

  state_t                 r_state, w_state_nxt;
  logic signed [DW-1:0]   r_hist [NTAPS];
  logic [AW-1:0]          r_wp, r_base, r_tap;
  logic                   r_mode;
  logic signed [2*DW-1:0] r_prod;
  logic signed [ACCW-1:0] r_acc;
  logic signed [DW-1:0]   r_dout;
  logic                   r_dout_vld, r_drop;

  logic                   w_busy, w_accept;
  logic [AW-1:0]          w_hidx;
  logic signed [DW-1:0]   w_x;
  logic signed [2*DW-1:0] w_prod;
  logic signed [ACCW-1:0] w_prod_ext, w_rnd, w_scaled;
  logic signed [DW-1:0]   w_sat;

  // The cycle that presents dout_valid still counts as busy, so the earliest next sample lands in cycle 36.
  assign w_busy   = (r_state != S_IDLE) || r_dout_vld;
  assign w_accept = io.din_valid && !w_busy;

  // Tap 0 reads the newest sample. Index arithmetic wraps naturally at AW bits.
  assign w_hidx     = r_base - r_tap;
  assign w_x        = r_hist[w_hidx];
  assign w_prod     = w_x * io.coef_in;
  assign w_prod_ext = ACCW'(r_prod);

  // Round half up, then drop the Q1.15 fraction with an arithmetic shift.
  assign w_rnd    = r_acc + RND;
  assign w_scaled = w_rnd >>> (DW - 1);

  // Clamp the scaled sum into the 16-bit signed output range.
  always_comb begin
    w_sat = w_scaled[DW-1:0];
    if (w_scaled > SAT_MAX)      w_sat = SAT_MAX[DW-1:0];
    else if (w_scaled < SAT_MIN) w_sat = SAT_MIN[DW-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> MAC (32 taps) -> FLUSH -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_MAC;
      S_MAC:   if (r_tap == LAST_TAP) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: history write, pipelined product, accumulate, output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) r_hist[i] <= '0;
      r_wp       <= '0;
      r_base     <= '0;
      r_tap      <= '0;
      r_mode     <= 1'b0;
      r_prod     <= '0;
      r_acc      <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_drop     <= r_drop | (io.din_valid & w_busy);
      r_dout_vld <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_hist[r_wp] <= io.din;
            r_base       <= r_wp;
            r_wp         <= r_wp + 1'b1;
            r_mode       <= io.mode_in;
            r_acc        <= '0;
            r_tap        <= '0;
          end
        end
        S_MAC: begin
          r_prod <= w_prod;
          // The product register is still empty on tap 0.
          if (r_tap != '0) r_acc <= r_acc + w_prod_ext;
          r_tap <= r_tap + 1'b1;
        end
        S_FLUSH: r_acc <= r_acc + w_prod_ext;
        S_DONE:  r_dout <= w_sat;
        default: ;
      endcase
    end
  end

  assign io.coef_addr  = (r_state == S_MAC) ? r_tap : '0;
  assign io.coef_mode  = r_mode;
  assign io.dout       = r_dout;
  assign io.dout_valid = r_dout_vld;
  assign io.busy       = w_busy;
  assign io.drop_err   = r_drop;
endmodule

// File: tb/tb_fir_serial_mac.sv
// Self-checking bench for fir_serial_mac. Expected outputs go into a queue when a sample is driven.
// A monitor pops that queue and compares on each dout_valid.
// The bench also plays the coefficient ROM, either as a real table or as a constant stub.
module tb_fir_serial_mac;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_serial_mac_if io ();
  fir_serial_mac dut (.clk(clk), .rst(rst), .io(io));

  // Coefficient ROM
  logic signed [15:0] rom_hp [32];
  logic signed [15:0] rom_lp [32];
  bit                 rom_stub_en = 1'b0;
  logic signed [15:0] rom_stub    = '0;

  assign io.coef_in = rom_stub_en ? rom_stub :
                      (io.coef_mode ? rom_hp[io.coef_addr] : rom_lp[io.coef_addr]);

  // Checking
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference FIR and scoreboard
  typedef struct {
    logic [15:0] v;
    int          cyc;
  } exp_t;

  exp_t               sb[$];
  logic [15:0]        got_q[$];
  logic signed [15:0] m_hist [32];
  int                 m_wp = 0;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_hist[i] = '0;
    m_wp = 0;
    sb.delete();
  endtask

  task automatic model_push(logic [15:0] x, logic m);
    longint             acc;
    longint             r;
    logic signed [15:0] c;
    exp_t               e;
    m_hist[m_wp] = x;
    acc = 0;
    for (int t = 0; t < 32; t++) begin
      c = rom_stub_en ? rom_stub : (m ? rom_hp[t] : rom_lp[t]);
      acc += longint'(m_hist[(m_wp - t) & 31]) * longint'(c);
    end
    r = (acc + 16384) >>> 15;
    if (r > 32767)       r = 32767;
    else if (r < -32768) r = -32768;
    e.v   = r[15:0];
    e.cyc = cyc;
    sb.push_back(e);
    m_wp = (m_wp + 1) & 31;
  endtask

  // Output monitor: compare against the scoreboard and log every output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && io.dout_valid) begin
        if (sb.size() == 0) chk("unexpected_dout_valid", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("dout", {16'h0, io.dout}, {16'h0, e.v});
          chk("latency", cyc - e.cyc, 32'd35);
        end
        got_q.push_back(io.dout);
      end
    end
  end

  // Stimulus helpers
  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while (io.busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic send(logic [15:0] x, logic m);
    wait_idle();
    io.din       = x;
    io.mode_in   = m;
    io.din_valid = 1'b1;
    model_push(x, m);
    @(negedge clk);
    io.din_valid = 1'b0;
    chk("busy_after_accept", {31'h0, io.busy}, 32'd1);
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("drain_timeout", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic impulse_check(string tag);
    int d;
    got_q.delete();
    send(16'h7FFF, 1'b1);
    for (int k = 1; k < 32; k++) send(16'h0000, 1'b1);
    drain();
    chk({tag, "_count"}, got_q.size(), 32'd32);
    for (int k = 0; k < 32 && k < got_q.size(); k++) begin
      d = int'($signed(got_q[k])) - int'(rom_hp[k]);
      chk(tag, {31'h0, (d >= -1 && d <= 1)}, 32'd1);
    end
  endtask

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  // Main sequence
  initial begin
    int t0, first_dv, dv_cnt;

    for (int k = 0; k < 32; k++) begin
      rom_hp[k] = (k % 2) ? 16'(-(k * 37)) : 16'(k * 53);
      rom_lp[k] = 16'(100 + k * 20);
    end
    rom_hp[15] = 16'h4E86;

    io.din = '0;
    io.din_valid = 1'b0;
    io.mode_in = 1'b0;
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_dout", {16'h0, io.dout}, 32'd0);
    chk("rst_dout_valid", {31'h0, io.dout_valid}, 32'd0);
    chk("rst_busy", {31'h0, io.busy}, 32'd0);
    chk("rst_drop_err", {31'h0, io.drop_err}, 32'd0);
    chk("rst_coef_addr", {27'h0, io.coef_addr}, 32'd0);
    chk("rst_coef_mode", {31'h0, io.coef_mode}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Impulse through the high-pass set
    impulse_check("impulse");

    // Random samples through the low-pass set
    for (int k = 0; k < 10; k++) send(16'($urandom), 1'b0);
    drain();

    // Mode hold and exact timing
    wait_idle();
    io.din = 16'h1234;
    io.mode_in = 1'b0;
    io.din_valid = 1'b1;
    model_push(16'h1234, 1'b0);
    t0 = cyc;
    first_dv = -1;
    dv_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) io.din_valid = 1'b0;
      if (k == 5) io.mode_in = 1'b1;
      if (k == 6 || k == 34) chk("mode_hold", {31'h0, io.coef_mode}, 32'd0);
      if (io.dout_valid) begin
        dv_cnt++;
        if (first_dv < 0) first_dv = cyc - t0;
      end
      if (k == 35) chk("busy_cycle35", {31'h0, io.busy}, 32'd1);
      if (k == 36) chk("busy_cycle36", {31'h0, io.busy}, 32'd0);
    end
    chk("dv_cycle", first_dv, 32'd35);
    chk("dv_width", dv_cnt, 32'd1);
    send(16'h0100, 1'b1);
    chk("mode_new_accept", {31'h0, io.coef_mode}, 32'd1);
    drain();

    // Overrun: an extra strobe in cycle 10 is dropped
    chk("drop_err_clear", {31'h0, io.drop_err}, 32'd0);
    wait_idle();
    io.din = 16'h2000;
    io.mode_in = 1'b1;
    io.din_valid = 1'b1;
    model_push(16'h2000, 1'b1);
    t0 = cyc;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1)  io.din_valid = 1'b0;
      if (k == 10) begin
        io.din = 16'h7ABC;
        io.mode_in = 1'b0;
        io.din_valid = 1'b1;
      end
      if (k == 11) begin
        io.din_valid = 1'b0;
        chk("drop_err_set", {31'h0, io.drop_err}, 32'd1);
      end
    end
    drain();
    send(16'hF000, 1'b1);
    drain();
    chk("drop_err_sticky", {31'h0, io.drop_err}, 32'd1);

    // Reset in the middle of a computation
    send(16'h4000, 1'b1);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_dout", {16'h0, io.dout}, 32'd0);
    chk("midrst_dout_valid", {31'h0, io.dout_valid}, 32'd0);
    chk("midrst_busy", {31'h0, io.busy}, 32'd0);
    chk("midrst_drop_err", {31'h0, io.drop_err}, 32'd0);
    chk("midrst_coef_mode", {31'h0, io.coef_mode}, 32'd0);
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    repeat (40) @(negedge clk);
    chk("midrst_no_output", got_q.size(), 32'd0);
    impulse_check("impulse_after_rst");

    // Unity DC with all coefficients 0x0400
    rom_stub_en = 1'b1;
    rom_stub = 16'h0400;
    pulse_reset();
    got_q.delete();
    for (int k = 0; k < 40; k++) send(16'h7FFF, 1'b0);
    drain();
    chk("dc_count", got_q.size(), 32'd40);
    if (got_q.size() == 40) begin
      chk("dc_first", {16'h0, got_q[0]}, 32'h0400);
      for (int k = 32; k < 40; k++) chk("dc_steady", {16'h0, got_q[k]}, 32'h7FFF);
    end

    // Saturation with all coefficients 0x7FFF
    rom_stub = 16'h7FFF;
    pulse_reset();
    got_q.delete();
    for (int k = 0; k < 32; k++) send(16'h7FFF, 1'b1);
    for (int k = 0; k < 32; k++) send(16'h8000, 1'b1);
    drain();
    chk("sat_count", got_q.size(), 32'd64);
    if (got_q.size() == 64) begin
      for (int k = 1; k < 32; k++) chk("sat_pos", {16'h0, got_q[k]}, 32'h7FFF);
      chk("sat_neg", {16'h0, got_q[63]}, 32'h8000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
